// File: rtl/whitening_stage.sv
// Whitening front end for the FastICA core: buffers a block of 4-channel
// samples, removes the per-channel mean, multiplies by the 4x4 matrix V and
// streams the whitened vectors back-to-back.
module whitening_stage #(
    parameter int N_SAMPLES = 128,
    parameter int LOG2_N    = 7,
    parameter int XW        = 16,
    parameter int ZW        = 26,
    parameter int FRAC      = 16
) (
    input  logic                 clk_white,
    input  logic                 rst_white,
    input  logic                 start,
    input  logic                 v_we,
    input  logic [3:0]           v_addr,
    input  logic signed [ZW-1:0] v_data,
    input  logic                 x_valid,
    input  logic signed [XW-1:0] x1,
    input  logic signed [XW-1:0] x2,
    input  logic signed [XW-1:0] x3,
    input  logic signed [XW-1:0] x4,
    output logic                 x_ready,
    output logic                 z_valid,
    output logic signed [ZW-1:0] z1,
    output logic signed [ZW-1:0] z2,
    output logic signed [ZW-1:0] z3,
    output logic signed [ZW-1:0] z4,
    output logic                 busy,
    output logic                 done
);
    localparam int SW = XW + LOG2_N;     // channel sum width
    localparam int CW = XW + 1;          // centred sample width
    localparam int PW = CW + ZW;         // product width
    localparam int AW = XW + ZW + 3;     // accumulator width
    localparam logic [LOG2_N-1:0]  LAST = LOG2_N'(N_SAMPLES - 1);
    localparam logic signed [AW-1:0] ZMAX = AW'(2**(ZW-1) - 1);
    localparam logic signed [AW-1:0] ZMIN = AW'(-(2**(ZW-1)));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MEAN, S_MAC, S_STREAM, S_DONE} state_t;
    state_t state, state_nxt;

    logic [LOG2_N-1:0]      cnt;       // sample index in LOAD/MAC/STREAM
    logic [LOG2_N-1:0]      cnt_inc;
    logic [1:0]             k;         // channel index within a MAC sample
    logic signed [SW-1:0]   sum  [4];
    logic signed [XW-1:0]   mean [4];
    logic signed [XW-1:0]   xin  [4];
    logic signed [ZW-1:0]   v_mem [16];
    logic [4*XW-1:0]        xbuf [N_SAMPLES];
    logic [4*ZW-1:0]        rbuf [N_SAMPLES];
    logic [4*XW-1:0]        xrow;
    logic signed [XW-1:0]   xk;
    logic signed [CW-1:0]   c_cur;
    logic [4*ZW-1:0]        zres;

    assign xin[0]  = x1;
    assign xin[1]  = x2;
    assign xin[2]  = x3;
    assign xin[3]  = x4;
    assign cnt_inc = cnt + 1'b1;

    // Centred value of the channel currently being multiplied
    assign xrow  = xbuf[cnt];
    assign xk    = xrow[k*XW +: XW];
    assign c_cur = CW'(xk) - CW'(mean[k]);

    // State register
    always_ff @(posedge clk_white or posedge rst_white) begin
        if (rst_white) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        z_valid   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                x_ready = 1'b1;
                if (x_valid && cnt == LAST) state_nxt = S_MEAN;
            end
            S_MEAN:   state_nxt = S_MAC;
            S_MAC:    if (k == 2'd3 && cnt == LAST) state_nxt = S_STREAM;
            S_STREAM: begin
                z_valid = 1'b1;
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One row of the matrix product per generate instance; each row owns its
    // multiplier and accumulator and produces the saturated z for that row.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic signed [ZW-1:0] vk;
        logic signed [PW-1:0] prod;
        logic signed [AW-1:0] acc, acc_nxt, sh;

        assign vk      = v_mem[{2'(r), k}];
        assign prod    = c_cur * vk;
        assign acc_nxt = acc + AW'(prod);
        assign sh      = acc_nxt >>> FRAC;
        assign zres[r*ZW +: ZW] = (sh > ZMAX) ? ZMAX[ZW-1:0] :
                                  (sh < ZMIN) ? ZMIN[ZW-1:0] : sh[ZW-1:0];

        // Accumulate four products per sample, clear after the last channel
        always_ff @(posedge clk_white or posedge rst_white) begin
            if (rst_white)                      acc <= '0;
            else if (state == S_MEAN)           acc <= '0;
            else if (state == S_MAC)            acc <= (k == 2'd3) ? '0 : acc_nxt;
        end
    end

    // Counters, sums, means, V storage and registered z outputs
    always_ff @(posedge clk_white or posedge rst_white) begin
        if (rst_white) begin
            cnt <= '0;
            k   <= '0;
            for (int i = 0; i < 4; i++) begin
                sum[i]  <= '0;
                mean[i] <= '0;
            end
            for (int i = 0; i < 16; i++)
                v_mem[i] <= (i % 5 == 0) ? ZW'(1 << FRAC) : '0;
            {z4, z3, z2, z1} <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (v_we) v_mem[v_addr] <= v_data;
                    if (start) begin
                        cnt <= '0;
                        for (int i = 0; i < 4; i++) sum[i] <= '0;
                    end
                end
                S_LOAD: if (x_valid) begin
                    cnt <= cnt_inc;
                    for (int i = 0; i < 4; i++) sum[i] <= sum[i] + SW'(xin[i]);
                end
                S_MEAN: begin
                    for (int i = 0; i < 4; i++) mean[i] <= XW'(sum[i] >>> LOG2_N);
                    cnt <= '0;
                    k   <= '0;
                end
                S_MAC: begin
                    k <= k + 1'b1;
                    if (k == 2'd3) begin
                        cnt <= cnt_inc;
                        // Preload the first result so STREAM starts with data
                        if (cnt == LAST) {z4, z3, z2, z1} <= rbuf[0];
                    end
                end
                S_STREAM: begin
                    cnt <= cnt_inc;
                    if (cnt == LAST) {z4, z3, z2, z1} <= '0;
                    else             {z4, z3, z2, z1} <= rbuf[cnt_inc];
                end
                S_DONE: begin
                    cnt <= '0;
                    {z4, z3, z2, z1} <= '0;
                end
                default: ;
            endcase
        end
    end

    // Sample and result buffers; contents survive reset
    always_ff @(posedge clk_white) begin
        if (state == S_LOAD && x_valid) xbuf[cnt] <= {x4, x3, x2, x1};
        if (state == S_MAC && k == 2'd3) rbuf[cnt] <= zres;
    end
endmodule
